// File: rtl/conv_loader_if.sv
// Signal bundle between the conv loader and its surroundings: byte stream in,
// 3x3 weights / 4x4 map / control to the conv engine, result stream out.
interface conv_loader_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       reuse_w;

   logic [7:0] w_11, w_12, w_13, w_21, w_22, w_23, w_31, w_32, w_33;
   logic [7:0] in_11, in_12, in_13, in_14, in_21, in_22, in_23, in_24;
   logic [7:0] in_31, in_32, in_33, in_34, in_41, in_42, in_43, in_44;

   logic       weight_load;
   logic       start;
   logic       done;
   logic [7:0] conv_out_11, conv_out_12, conv_out_21, conv_out_22;

   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;

   logic       busy;
   logic       err_timeout;

   // master is the loader itself; slave is the stream source/sink and conv engine
   modport master (
      input  s_valid, s_data, reuse_w, done, m_ready,
      input  conv_out_11, conv_out_12, conv_out_21, conv_out_22,
      output s_ready, weight_load, start, m_valid, m_data, busy, err_timeout,
      output w_11, w_12, w_13, w_21, w_22, w_23, w_31, w_32, w_33,
      output in_11, in_12, in_13, in_14, in_21, in_22, in_23, in_24,
      output in_31, in_32, in_33, in_34, in_41, in_42, in_43, in_44
   );

   modport slave (
      output s_valid, s_data, reuse_w, done, m_ready,
      output conv_out_11, conv_out_12, conv_out_21, conv_out_22,
      input  s_ready, weight_load, start, m_valid, m_data, busy, err_timeout,
      input  w_11, w_12, w_13, w_21, w_22, w_23, w_31, w_32, w_33,
      input  in_11, in_12, in_13, in_14, in_21, in_22, in_23, in_24,
      input  in_31, in_32, in_33, in_34, in_41, in_42, in_43, in_44
   );
endinterface

// File: rtl/conv_loader.sv
// Loads 3x3 weights and a 4x4 input map from a byte stream, kicks the conv
// engine, waits for done (with timeout) and streams the four results out.
module conv_loader #(
   parameter int TIMEOUT = 31
) (
   input logic           clk,
   input logic           rst,
   conv_loader_if.master io_bus
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {LOAD_W, LOAD_A, WLOAD, START, WAIT, OUT} state_t;

   state_t         r_state;
   state_t         w_next;
   state_t         w_boundary;
   logic [3:0]     r_byteCnt;
   logic [CW-1:0]  r_waitCnt;
   logic [1:0]     r_outIdx;
   logic           r_wv;
   logic           r_wThisFrame;
   logic           r_err;
   logic [7:0]     r_w   [9];
   logic [7:0]     r_in  [16];
   logic [7:0]     r_res [4];

   logic           w_loading;
   logic           w_accept;
   logic           w_lastWait;

   assign w_loading  = (r_state == LOAD_W) || (r_state == LOAD_A);
   assign w_accept   = io_bus.s_valid && io_bus.s_ready;
   // WAIT lasts at most TIMEOUT cycles (counter values 0 .. TIMEOUT-1)
   assign w_lastWait = (r_waitCnt == CW'(TIMEOUT - 1));
   assign w_boundary = (io_bus.reuse_w && r_wv) ? LOAD_A : LOAD_W;

   always_ff @(posedge clk) begin
      if (rst) r_state <= LOAD_W;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD_W: if (w_accept && r_byteCnt == 4'd8) w_next = LOAD_A;
         LOAD_A: if (w_accept && r_byteCnt == 4'd15) w_next = r_wThisFrame ? WLOAD : START;
         WLOAD:  w_next = START;
         START:  w_next = WAIT;
         WAIT: begin
            if (io_bus.done)     w_next = OUT;
            else if (w_lastWait) w_next = w_boundary;
         end
         OUT:    if (io_bus.m_ready && r_outIdx == 2'd3) w_next = w_boundary;
         default: w_next = LOAD_W;
      endcase
   end

   // One byte counter serves both load phases; it wraps to 0 at the end of each.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_byteCnt    <= '0;
         r_waitCnt    <= '0;
         r_outIdx     <= '0;
         r_wv         <= 1'b0;
         r_wThisFrame <= 1'b0;
         r_err        <= 1'b0;
         for (int i = 0; i < 9; i++)  r_w[i]   <= '0;
         for (int i = 0; i < 16; i++) r_in[i]  <= '0;
         for (int i = 0; i < 4; i++)  r_res[i] <= '0;
      end else begin
         case (r_state)
            LOAD_W: begin
               if (w_accept) begin
                  r_w[r_byteCnt] <= io_bus.s_data;
                  if (r_byteCnt == 4'd8) begin
                     r_byteCnt    <= '0;
                     r_wv         <= 1'b1;
                     r_wThisFrame <= 1'b1;
                  end else begin
                     r_byteCnt <= r_byteCnt + 4'd1;
                  end
               end
            end
            LOAD_A: begin
               if (w_accept) begin
                  r_in[r_byteCnt] <= io_bus.s_data;
                  r_byteCnt       <= r_byteCnt + 4'd1;
                  if (r_byteCnt == 4'd15) r_wThisFrame <= 1'b0;
               end
            end
            START: r_waitCnt <= '0;
            WAIT: begin
               if (io_bus.done) begin
                  r_res[0] <= io_bus.conv_out_11;
                  r_res[1] <= io_bus.conv_out_12;
                  r_res[2] <= io_bus.conv_out_21;
                  r_res[3] <= io_bus.conv_out_22;
                  r_outIdx <= '0;
               end else if (w_lastWait) begin
                  r_err <= 1'b1;
               end else begin
                  r_waitCnt <= r_waitCnt + CW'(1);
               end
            end
            OUT: if (io_bus.m_ready) r_outIdx <= r_outIdx + 2'd1;
            default: ;
         endcase
      end
   end

   assign io_bus.s_ready     = w_loading && !rst;
   assign io_bus.busy        = !w_loading;
   assign io_bus.weight_load = (r_state == WLOAD);
   assign io_bus.start       = (r_state == START);
   assign io_bus.m_valid     = (r_state == OUT);
   assign io_bus.m_data      = r_res[r_outIdx];
   assign io_bus.err_timeout = r_err;

   assign io_bus.w_11  = r_w[0];   assign io_bus.w_12  = r_w[1];   assign io_bus.w_13  = r_w[2];
   assign io_bus.w_21  = r_w[3];   assign io_bus.w_22  = r_w[4];   assign io_bus.w_23  = r_w[5];
   assign io_bus.w_31  = r_w[6];   assign io_bus.w_32  = r_w[7];   assign io_bus.w_33  = r_w[8];

   assign io_bus.in_11 = r_in[0];  assign io_bus.in_12 = r_in[1];  assign io_bus.in_13 = r_in[2];
   assign io_bus.in_14 = r_in[3];  assign io_bus.in_21 = r_in[4];  assign io_bus.in_22 = r_in[5];
   assign io_bus.in_23 = r_in[6];  assign io_bus.in_24 = r_in[7];  assign io_bus.in_31 = r_in[8];
   assign io_bus.in_32 = r_in[9];  assign io_bus.in_33 = r_in[10]; assign io_bus.in_34 = r_in[11];
   assign io_bus.in_41 = r_in[12]; assign io_bus.in_42 = r_in[13]; assign io_bus.in_43 = r_in[14];
   assign io_bus.in_44 = r_in[15];
endmodule

// File: tb/tb_conv_loader.sv
// Self-checking bench for conv_loader: a stub conv engine, a result scoreboard
// and a register model of the weights and input map.
module tb_conv_loader;
   localparam int TIMEOUT = 31;

   logic clk;
   logic rst;
   conv_loader_if bus ();

   conv_loader #(.TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int          checkCount = 0;
   int          errorCount = 0;
   logic [7:0]  expQ [$];
   int          hsCycles [$];
   logic [7:0]  expW  [9];
   logic [7:0]  expIn [16];
   logic [7:0]  obsW  [9];
   logic [7:0]  obsIn [16];
   int          cycle = 0;
   int          wlCount = 0;
   int          startCount = 0;
   int          mValidCount = 0;
   int          startCycle = -1;
   int          errCycle = -1;
   int          stallLeft = 0;
   bit          stubEnable = 1'b0;
   int          stubDelay = 13;
   int          stubCnt = 0;
   bit          stubActive = 1'b0;
   logic [31:0] convVals = 32'h0;

   assign obsW[0] = bus.w_11;  assign obsW[1] = bus.w_12;  assign obsW[2] = bus.w_13;
   assign obsW[3] = bus.w_21;  assign obsW[4] = bus.w_22;  assign obsW[5] = bus.w_23;
   assign obsW[6] = bus.w_31;  assign obsW[7] = bus.w_32;  assign obsW[8] = bus.w_33;
   assign obsIn[0]  = bus.in_11; assign obsIn[1]  = bus.in_12; assign obsIn[2]  = bus.in_13;
   assign obsIn[3]  = bus.in_14; assign obsIn[4]  = bus.in_21; assign obsIn[5]  = bus.in_22;
   assign obsIn[6]  = bus.in_23; assign obsIn[7]  = bus.in_24; assign obsIn[8]  = bus.in_31;
   assign obsIn[9]  = bus.in_32; assign obsIn[10] = bus.in_33; assign obsIn[11] = bus.in_34;
   assign obsIn[12] = bus.in_41; assign obsIn[13] = bus.in_42; assign obsIn[14] = bus.in_43;
   assign obsIn[15] = bus.in_44;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Stub conv engine: done pulses stubDelay cycles after the start cycle; results are only valid with done.
   always @(posedge clk) begin
      if (rst) begin
         stubActive <= 1'b0;
         stubCnt    <= 0;
         bus.done   <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (bus.start && stubEnable) begin
            stubActive <= 1'b1;
            stubCnt    <= 1;
         end else if (stubActive) begin
            stubCnt <= stubCnt + 1;
            if (stubCnt + 1 == stubDelay) begin
               bus.done   <= 1'b1;
               stubActive <= 1'b0;
            end
         end
      end
   end

   assign bus.conv_out_11 = bus.done ? convVals[31:24] : 8'hEE;
   assign bus.conv_out_12 = bus.done ? convVals[23:16] : 8'hEE;
   assign bus.conv_out_21 = bus.done ? convVals[15:8]  : 8'hEE;
   assign bus.conv_out_22 = bus.done ? convVals[7:0]   : 8'hEE;

   // Monitor on the falling edge: pulse counters, timing marks and the result scoreboard.
   always @(negedge clk) begin
      cycle++;
      if (bus.weight_load) wlCount++;
      if (bus.start) begin
         startCount++;
         startCycle = cycle;
      end
      if (bus.err_timeout === 1'b1 && errCycle < 0) errCycle = cycle;
      if (bus.m_valid === 1'b1) begin
         mValidCount++;
         if (bus.m_ready) begin
            hsCycles.push_back(cycle);
            checkOutput("sbEmpty", expQ.size() == 0, 0);
            if (expQ.size() > 0) checkOutput("m_data", bus.m_data, expQ.pop_front());
         end else if (expQ.size() > 0) begin
            checkOutput("m_dataHold", bus.m_data, expQ[0]);
         end
      end
   end

   task automatic checkRegs(input string tag);
      for (int i = 0; i < 9; i++)  checkOutput($sformatf("%s w[%0d]", tag, i), obsW[i], expW[i]);
      for (int i = 0; i < 16; i++) checkOutput($sformatf("%s in[%0d]", tag, i), obsIn[i], expIn[i]);
   endtask

   // Entered and left at posedge+1; every byte must be accepted within a bounded number of tries.
   task automatic sendByte(input logic [7:0] data, input bit gaps);
      bit accepted = 1'b0;
      for (int n = 0; n < 100 && !accepted; n++) begin
         bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.s_data  = data;
         @(negedge clk);
         accepted = bus.s_valid && bus.s_ready;
         @(posedge clk);
         #1;
      end
      bus.s_valid = 1'b0;
      checkOutput("byteAccepted", accepted, 1);
   endtask

   task automatic waitFrameEnd();
      bit ended = 1'b0;
      for (int n = 0; n < 400 && !ended; n++) begin
         @(negedge clk);
         if (bus.s_ready) ended = 1'b1;
         @(posedge clk);
         #1;
         if (stallLeft > 0 && hsCycles.size() == 1) begin
            bus.m_ready = 1'b0;
            stallLeft--;
         end else begin
            bus.m_ready = 1'b1;
         end
      end
      checkOutput("frameEnd", ended, 1);
   endtask

   task automatic applyStimulus(input bit sendW, input logic [7:0] wBase, input logic [7:0] aBase,
                                input bit gaps, input bit stubOn, input int delay,
                                input logic [31:0] conv, input bit nextReuse, input int stall);
      logic [7:0] b;
      hsCycles.delete();
      wlCount     = 0;
      startCount  = 0;
      mValidCount = 0;
      stubEnable  = stubOn;
      stubDelay   = delay;
      convVals    = conv;
      bus.reuse_w = nextReuse;
      bus.m_ready = 1'b1;
      stallLeft   = stall;
      if (stubOn) for (int i = 0; i < 4; i++) expQ.push_back(conv[31-8*i -: 8]);
      if (sendW) begin
         for (int i = 0; i < 9; i++) begin
            b = wBase + 8'(i);
            sendByte(b, gaps);
            expW[i] = b;
         end
      end
      for (int i = 0; i < 16; i++) begin
         b = aBase + 8'(i);
         sendByte(b, gaps);
         expIn[i] = b;
      end
      waitFrameEnd();
      checkOutput("weightLoadPulses", wlCount, sendW ? 1 : 0);
      checkOutput("startPulses", startCount, 1);
      checkOutput("sbDrained", expQ.size(), 0);
      checkOutput("handshakes", hsCycles.size(), stubOn ? 4 : 0);
      checkOutput("mValidCycles", mValidCount, stubOn ? 4 + stall : 0);
      if (stubOn && hsCycles.size() == 4) checkOutput("hsSpan", hsCycles[3] - hsCycles[0], 3 + stall);
      checkRegs("frame");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      bus.reuse_w = 1'b0;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 9; i++)  expW[i]  = 8'h00;
      for (int i = 0; i < 16; i++) expIn[i] = 8'h00;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst s_ready", bus.s_ready, 0);
      checkOutput("rst m_valid", bus.m_valid, 0);
      checkOutput("rst err", bus.err_timeout, 0);
      checkOutput("rst busy", bus.busy, 0);
      checkRegs("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRst s_ready", bus.s_ready, 1);
      @(posedge clk); #1;

      // Frame A: full load, reuse weights for the next frame
      applyStimulus(1'b1, 8'h01, 8'h10, 1'b0, 1'b1, 13, 32'h11223344, 1'b1, 0);
      // Frame B: map only, weights reused
      applyStimulus(1'b0, 8'h00, 8'h20, 1'b0, 1'b1, 13, 32'h55667788, 1'b0, 0);
      // Frame C: same data as A with random input gaps and a 5-cycle output stall
      applyStimulus(1'b1, 8'h01, 8'h10, 1'b1, 1'b1, 13, 32'h11223344, 1'b0, 5);
      // Frame D: done arrives on the last allowed WAIT cycle and must win over the timeout
      applyStimulus(1'b1, 8'hA1, 8'hB0, 1'b0, 1'b1, TIMEOUT, 32'h9AABBCCD, 1'b0, 0);
      checkOutput("doneWins err", bus.err_timeout, 0);

      // Frame E: engine never answers
      errCycle = -1;
      applyStimulus(1'b1, 8'h61, 8'h70, 1'b0, 1'b0, 13, 32'h0, 1'b0, 0);
      checkOutput("timeout err", bus.err_timeout, 1);
      checkOutput("timeout latency", errCycle - startCycle, TIMEOUT + 1);

      // Frame F: after the timeout the loader is back in LOAD_W; reset mid-map
      sendByte(8'hC0, 1'b0);
      checkOutput("afterTimeout w_11", bus.w_11, 8'hC0);
      checkOutput("err sticky", bus.err_timeout, 1);
      for (int i = 1; i < 9; i++) sendByte(8'hC0 + 8'(i), 1'b0);
      for (int i = 0; i < 7; i++) sendByte(8'hD0 + 8'(i), 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRst s_ready", bus.s_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      for (int i = 0; i < 9; i++)  expW[i]  = 8'h00;
      for (int i = 0; i < 16; i++) expIn[i] = 8'h00;
      checkRegs("midRst");
      checkOutput("midRst err", bus.err_timeout, 0);
      checkOutput("midRst m_valid", bus.m_valid, 0);
      checkOutput("midRst m_data", bus.m_data, 0);
      checkOutput("midRst start", bus.start, 0);
      checkOutput("midRst weight_load", bus.weight_load, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      applyStimulus(1'b1, 8'h31, 8'h41, 1'b0, 1'b1, 13, 32'h01020304, 1'b0, 0);
      checkOutput("final err", bus.err_timeout, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
